// File: rtl/jk_updown_counter.sv
// jk_updown_counter: synchronous modulo-MODULUS up/down counter built from a
// bank of JK flip-flop cells, one cell per count bit.
//
// The control logic works out J/K for every cell from the current count and
// the direction, enable and load inputs. The counter also drives a
// terminal-count flag (combinational) and a wrap flag (registered).
//
// Optional build macro: JK_COUNTER_STICKY_WRAP_EN
//   undefined (default): wrap is a one-cycle pulse in the cycle that first
//                        shows the wrapped count.
//   defined            : wrap sets on any wrap transition and holds until
//                        reset or load clears it.

// Single JK flip-flop cell with synchronous active-high reset.
module jk_cell (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   // JK truth table: hold / clear / set / toggle, reset has priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b00:   q <= q;
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            default: q <= ~q;
         endcase
      end
   end

endmodule

// Counter control stage plus the bank of JK cells it drives.
module jk_updown_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   // The modulus must be representable and give a sequence of at least two.
   generate
      if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
         $error("jk_updown_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
      end
   endgenerate

   // Last legal count value, and the modulus widened by one bit so that
   // MODULUS == 2**WIDTH is still representable for range comparisons.
   localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] j_drv;
   logic [WIDTH-1:0] k_drv;
   logic [WIDTH-1:0] tog_up;
   logic [WIDTH-1:0] tog_dn;
   logic [WIDTH-1:0] load_val;
   logic             at_last;
   logic             at_zero;
   logic             out_of_range;
   logic             din_ok;
   logic             wrap_up;
   logic             wrap_dn;
   logic             wrap_evt;

   // One JK cell per count bit; count comes straight from the cell outputs.
   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_cell
         jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j_drv[g]),
            .k     (k_drv[g]),
            .q     (count[g])
         );
      end
   endgenerate

   // Count decode. A count at or above MODULUS can only arise from a fault;
   // an up step from there returns to 0, while a down step simply decrements
   // through the ordinary borrow chain.
   assign at_last      = (count == LAST);
   assign at_zero      = (count == '0);
   assign out_of_range = ({1'b0, count} >= MOD_EXT);

   // Load target: out-of-range load values are replaced by 0.
   assign din_ok   = ({1'b0, din} < MOD_EXT);
   assign load_val = din_ok ? din : '0;

   assign wrap_up  = en && up && (at_last || out_of_range);
   assign wrap_dn  = en && !up && at_zero;
   assign wrap_evt = !load && (wrap_up || wrap_dn);

   assign tc = en && ((up && at_last) || (!up && at_zero));

   // Toggle masks for the classic synchronous JK counter: bit i toggles on
   // an up step when all lower bits are 1, on a down step when all are 0.
   always_comb begin
      logic carry;
      logic borrow;
      tog_up = '0;
      tog_dn = '0;
      carry  = 1'b1;
      borrow = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         tog_up[i] = carry;
         tog_dn[i] = borrow;
         carry     = carry & count[i];
         borrow    = borrow & ~count[i];
      end
   end

   // Per-bit J/K drive in priority load > count > hold. Reset needs no
   // drive here because it goes straight into the cells' own reset.
   always_comb begin
      j_drv = '0;
      k_drv = '0;
      if (load) begin
         j_drv = load_val;
         k_drv = ~load_val;
      end else if (en) begin
         if (up) begin
            if (wrap_up) begin
               j_drv = '0;
               k_drv = '1;
            end else begin
               j_drv = tog_up;
               k_drv = tog_up;
            end
         end else begin
            if (wrap_dn) begin
               j_drv = LAST;
               k_drv = ~LAST;
            end else begin
               j_drv = tog_dn;
               k_drv = tog_dn;
            end
         end
      end
   end

`ifdef JK_COUNTER_STICKY_WRAP_EN
   // Sticky wrap flag: set by any wrap transition, cleared only by reset or load.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrap <= 1'b0;
      end else if (load) begin
         wrap <= 1'b0;
      end else if (wrap_evt) begin
         wrap <= 1'b1;
      end
   end
`else
   // Wrap pulse: high for exactly the cycle that first shows the wrapped count.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrap <= 1'b0;
      end else begin
         wrap <= wrap_evt;
      end
   end
`endif

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed testbench for jk_updown_counter (WIDTH=4, MODULUS=10).
// Expected values are written out by hand for each vector.
module tb_jk_updown_counter;

`ifdef JK_COUNTER_STICKY_WRAP_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] din;
   logic [3:0] count;
   logic       tc;
   logic       wrap;

   int checks;
   int errors;

   jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .up    (up),
      .load  (load),
      .din   (din),
      .count (count),
      .tc    (tc),
      .wrap  (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look(input string tag, input int c, input int t, input int w);
      #1;
      check({tag, ".count"}, int'(count), c);
      check({tag, ".tc"},    int'(tc),    t);
      check({tag, ".wrap"},  int'(wrap),  w);
   endtask

   int up_cnt [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
   int up_tc  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
   int up_wr  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0;
      step();
      look("reset", 0, 0, 0);

      // Count up through the wrap.
      reset = 1'b0; en = 1'b1; up = 1'b1;
      for (int k = 0; k < 12; k++) begin
         look($sformatf("up%0d", k), up_cnt[k], up_tc[k],
              (up_wr[k] == 1 || (STICKY && k == 11)) ? 1 : 0);
         step();
      end

      // Count down from reset: 0 -> 9 -> 8.
      reset = 1'b1; en = 1'b0;
      step();
      reset = 1'b0; en = 1'b1; up = 1'b0;
      look("dn0", 0, 1, 0);
      step();
      look("dn1", 9, 0, 1);
      step();
      look("dn2", 8, 0, STICKY ? 1 : 0);

      // Load overrides en/up; out-of-range load gives 0 and suppresses wrap.
      load = 1'b1; din = 4'd7; en = 1'b1; up = 1'b1;
      step();
      look("ld7", 7, 0, 0);
      din = 4'd9;
      step();
      load = 1'b0; en = 1'b0;
      look("ld9", 9, 0, 0);
      load = 1'b1; din = 4'd12; en = 1'b1; up = 1'b1;
      step();
      load = 1'b0; en = 1'b0;
      look("ld12", 0, 0, 0);
      load = 1'b1; din = 4'd10;
      step();
      load = 1'b0;
      look("ld10", 0, 0, 0);

      // Count to 5, then hold for three cycles.
      en = 1'b1; up = 1'b1;
      for (int k = 0; k < 5; k++) step();
      en = 1'b0;
      look("cnt5", 5, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         look($sformatf("hold%0d", k), 5, 0, 0);
      end

      // Direction change without turnaround: 5 up -> 6, then down -> 5.
      en = 1'b1; up = 1'b1;
      step();
      up = 1'b0;
      look("turn6", 6, 0, 0);
      step();
      look("turn5", 5, 0, 0);

      // Run up to 9, then reset and en together: no wrap pulse.
      up = 1'b1;
      for (int k = 0; k < 4; k++) step();
      look("at9", 9, 1, 0);
      en = 1'b0;
      look("at9_noen", 9, 0, 0);
      reset = 1'b1; en = 1'b1; up = 1'b1;
      step();
      reset = 1'b0; en = 1'b0;
      look("rst_en", 0, 0, 0);
      step();
      look("rst_after", 0, 0, 0);

`ifdef JK_COUNTER_STICKY_WRAP_EN
      // Sticky wrap: survives further counting, cleared by load.
      load = 1'b1; din = 4'd9;
      step();
      load = 1'b0; en = 1'b1; up = 1'b1;
      step();
      look("sticky0", 0, 0, 1);
      for (int k = 0; k < 5; k++) step();
      en = 1'b0;
      look("sticky5", 5, 0, 1);
      step();
      look("sticky_hold", 5, 0, 1);
      load = 1'b1; din = 4'd3;
      step();
      load = 1'b0;
      look("sticky_ld3", 3, 0, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: got %0d expected %0d", 0, 1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/jk_updown_counter.md
# jk_updown_counter

Synchronous modulo-N up/down counter built from a bank of the team's JK flip-flop cells, one cell per count bit, sharing clk and reset. The block generates per-bit J/K drive from the current count, direction, enable and parallel-load inputs, and exposes the stored count plus terminal-count and wrap flags. It is the control stage that feeds the JK cells directly. Downstream sequencing logic uses it as the standard event/divider counter.

## Interface
- WIDTH, 4: count width in bits; one JK cell per bit.
- MODULUS, 10: count sequence length; legal range 2..2^WIDTH. Out-of-range values are an elaboration error.

- clk  input  1  rising-edge clock for all JK cells.
- reset  input  1  reset, synchronous, active-high; clock clk.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled with en.
- load  input  1  parallel load strobe.
- din  input  WIDTH  parallel load value.
- count  output  WIDTH  current count, straight from the JK cell q outputs.
- tc  output  1  terminal count: combinational, `en && ((up && count==MODULUS-1) || (!up && count==0))`.
- wrap  output  1  registered one-cycle pulse in the cycle after a wrap transition.

## Operation
- Priority per clock edge: reset > load > en > hold.
- Reset: count=0, wrap=0. Driven through the JK cells' own synchronous reset.
- Hold (en=0, load=0): every cell gets J=K=0, so count is unchanged. wrap is 0 the next cycle.
- Count up, no wrap: bit i gets J=K=1 (toggle) when all bits below i are 1, else J=K=0. This is the standard synchronous JK counter.
- Count down, no wrap: bit i toggles when all bits below i are 0.
- Wrap up (count==MODULUS-1, en=1, up=1): next count=0, applied as J=0, K=1 on all bits. wrap=1 next cycle.
- Wrap down (count==0, en=1, up=0): next count=MODULUS-1, applied as J=n_i, K=~n_i per bit. wrap=1 next cycle.
- Load: target v = din if din<MODULUS, else 0. Each bit gets J=v_i, K=~v_i. wrap=0. Load overrides en and up in the same cycle.
- Count outside 0..MODULUS-1 is unreachable; it can be entered only via a bug. If entered, an up step goes to 0 and a down step goes to count-1.
- When MODULUS==2^WIDTH, natural binary rollover and the wrap logic agree. tc and wrap behave identically.

## Timing
- Latency: count reflects en/load/reset one clock after the sampling edge.
- tc is combinational from registered count and the live en/up. It is valid in the same cycle, before the edge that wraps.
- wrap is asserted exactly one cycle, aligned with the first cycle that shows the wrapped count.
- Reset mid-sequence: the next edge gives count=0 and wrap=0, regardless of load or en.
- Toggling up while en=1 takes effect on that cycle's edge. There is no turnaround cycle.
- All outputs are glitch-free except tc, which is combinational.

## Configuration
- JK_COUNTER_STICKY_WRAP_EN: when defined, wrap is sticky. It sets on any wrap transition and holds until reset or load clears it. It is not cleared by hold or count cycles.
- Without the macro, wrap is the one-cycle pulse described above.

## Test plan
- Reset then en=1, up=1 for 12 cycles (WIDTH=4, MODULUS=10) -> count 0,1,…,9,0,1. tc=1 only while count=9. wrap=1 only in the cycle showing the first 0 after 9.
- Reset then en=1, up=0 -> count 0→9→8. tc=1 in cycle with count=0. wrap pulse when count shows 9.
- load=1, din=7, en=1, up=1 in the same cycle -> next count=7, not 8. Then din=12 loaded -> count=0, wrap=0.
- Count up to 5, drop en for 3 cycles -> count holds 5. All cells see J=K=0 and wrap stays 0.
- At count=9, assert reset and en together -> next count=0, wrap=0. No wrap pulse appears.
- With JK_COUNTER_STICKY_WRAP_EN: wrap 9→0, then count 5 more -> wrap stays 1. load din=3 -> wrap=0, count=3.
